ssd_bcd_scanner: RTL and testbench

Sequential display driver that sits directly downstream of the CPU's debug multiplexer. It consumes the 13-bit `num` value selected by `ssdSel` and converts it to four BCD digits with a multi-cycle shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto a 4-digit common-anode seven-segment display.

---
 rtl/ssd_pkg.sv | 29 ++
 rtl/bcd_seg_decoder.sv | 29 ++
 rtl/ssd_bcd_scanner.sv | 149 ++++++++++++++
 tb/tb_ssd_bcd_scanner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the BCD seven-segment scanner: FSM state codes,
// active-low segment patterns ({g,f,e,d,c,b,a}) and one-cold anode enables.
package ssd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StShift = 2'd1;
    localparam state_t StDone  = 2'd2;

    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] Seg1     = 7'b1111001;
    localparam logic [6:0] Seg2     = 7'b0100100;
    localparam logic [6:0] Seg3     = 7'b0110000;
    localparam logic [6:0] Seg4     = 7'b0011001;
    localparam logic [6:0] Seg5     = 7'b0010010;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg7     = 7'b1111000;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0010000;
    localparam logic [6:0] SegBlank = 7'b1111111;

    localparam logic [3:0] AnodeThou = 4'b0111;
    localparam logic [3:0] AnodeHund = 4'b1011;
    localparam logic [3:0] AnodeTens = 4'b1101;
    localparam logic [3:0] AnodeOnes = 4'b1110;
    localparam logic [3:0] AnodeOff  = 4'b1111;

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder with a blank override.
module bcd_seg_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SegBlank;
        if (!blank) begin
            case (digit)
                4'd0:    seg = Seg0;
                4'd1:    seg = Seg1;
                4'd2:    seg = Seg2;
                4'd3:    seg = Seg3;
                4'd4:    seg = Seg4;
                4'd5:    seg = Seg5;
                4'd6:    seg = Seg6;
                4'd7:    seg = Seg7;
                4'd8:    seg = Seg8;
                4'd9:    seg = Seg9;
                default: seg = SegBlank;
            endcase
        end
    end

endmodule

// File: rtl/ssd_bcd_scanner.sv
// Binary to BCD (shift-add-3) converter feeding a 4-digit multiplexed seven-segment scanner.
// Optional leading-zero blanking is enabled with `define SSD_LEADING_ZERO_BLANK_EN.
module ssd_bcd_scanner
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 18,
    parameter int unsigned NUM_W        = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] num,
    output logic [3:0]       Anode,
    output logic [6:0]       LED_out,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(NUM_W) + 1;

    state_t                  state_q, state_d;
    logic [CntW-1:0]         cnt_q;
    logic [NUM_W-1:0]        bin_sr_q;
    logic [15:0]             bcd_sr_q;
    logic [15:0]             bcd_adj;
    logic [NUM_W-1:0]        shown_bin_q;
    logic                    force_conv_q;
    logic [15:0]             digits_q;
    logic                    digits_valid_q;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [3:0]              anode_q, anode_sel;
    logic [6:0]              led_q, seg_sel;
    logic [3:0]              digit_sel;
    logic                    lz_blank;
    logic [1:0]              slot;

    logic start;
    assign start = (num != shown_bin_q) || force_conv_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (cnt_q == CntW'(NUM_W - 1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_sr_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_sr_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            bin_sr_q       <= '0;
            bcd_sr_q       <= '0;
            shown_bin_q    <= '0;
            force_conv_q   <= 1'b1;
            digits_q       <= '0;
            digits_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        bin_sr_q     <= num;
                        bcd_sr_q     <= '0;
                        cnt_q        <= '0;
                        shown_bin_q  <= num;
                        force_conv_q <= 1'b0;
                    end
                end
                StShift: begin
                    bcd_sr_q <= {bcd_adj[14:0], bin_sr_q[NUM_W-1]};
                    bin_sr_q <= bin_sr_q << 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                StDone: begin
                    digits_q       <= bcd_sr_q;
                    digits_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign slot = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        anode_sel = AnodeOff;
        digit_sel = 4'd0;
        lz_blank  = 1'b0;
        unique case (slot)
            2'd0: begin
                anode_sel = AnodeThou;
                digit_sel = digits_q[15:12];
`ifdef SSD_LEADING_ZERO_BLANK_EN
                lz_blank  = (digits_q[15:12] == 4'd0);
`endif
            end
            2'd1: begin
                anode_sel = AnodeHund;
                digit_sel = digits_q[11:8];
`ifdef SSD_LEADING_ZERO_BLANK_EN
                lz_blank  = (digits_q[15:8] == 8'd0);
`endif
            end
            2'd2: begin
                anode_sel = AnodeTens;
                digit_sel = digits_q[7:4];
`ifdef SSD_LEADING_ZERO_BLANK_EN
                lz_blank  = (digits_q[15:4] == 12'd0);
`endif
            end
            default: begin
                anode_sel = AnodeOnes;
                digit_sel = digits_q[3:0];
            end
        endcase
    end

    // Nothing is lit until the first post-reset conversion has completed.
    bcd_seg_decoder u_dec (
        .digit (digit_sel),
        .blank (!digits_valid_q || lz_blank),
        .seg   (seg_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_q <= '0;
            anode_q   <= AnodeOff;
            led_q     <= SegBlank;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            anode_q   <= anode_sel;
            led_q     <= seg_sel;
        end
    end

    assign Anode   = anode_q;
    assign LED_out = led_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_ssd_bcd_scanner.sv
// Self-checking bench for ssd_bcd_scanner with a short refresh counter (REFRESH_BITS=4).
module tb_ssd_bcd_scanner;

    localparam int RB = 4;
    localparam int NW = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] num = 13'd0;
    logic [3:0]  Anode;
    logic [6:0]  LED_out;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ssd_bcd_scanner #(
        .REFRESH_BITS (RB),
        .NUM_W        (NW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .num     (num),
        .Anode   (Anode),
        .LED_out (LED_out),
        .busy    (busy)
    );

    // Scan position model: a free-running cycle count since reset release.
    int   tb_ref = 0;
    int   prev_slot = 0;
    logic prev_rst_low = 1'b1;
    always @(posedge clk) begin
        prev_rst_low <= !rst;
        prev_slot    <= tb_ref / (1 << (RB - 2));
        tb_ref       <= rst ? (tb_ref + 1) % (1 << RB) : 0;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] anode_of(input int s);
        case (s)
            0: return 4'b0111;
            1: return 4'b1011;
            2: return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [6:0] exp_led(input int value, input int s);
        int d;
        bit blank;
        blank = 1'b0;
        case (s)
            0: d = (value / 1000) % 10;
            1: d = (value / 100) % 10;
            2: d = (value / 10) % 10;
            default: d = value % 10;
        endcase
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (s == 0 && value < 1000) blank = 1'b1;
        if (s == 1 && value < 100)  blank = 1'b1;
        if (s == 2 && value < 10)   blank = 1'b1;
`endif
        return blank ? 7'b1111111 : seg_of(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL %s conversion timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic check_scan(input int value, input string name, input int n);
        logic [3:0] ea;
        logic [6:0] el;
        tick();
        for (int i = 0; i < n; i++) begin
            tick();
            ea = prev_rst_low ? 4'b1111 : anode_of(prev_slot);
            el = prev_rst_low ? 7'b1111111 : exp_led(value, prev_slot);
            tests++;
            if (Anode !== ea) begin
                failed++;
                $display("FAIL %s anode: got %b required %b", name, Anode, ea);
            end
            tests++;
            if (LED_out !== el) begin
                failed++;
                $display("FAIL %s led value %0d: got %b required %b", name, value, LED_out, el);
            end
        end
    endtask

    task automatic start_conv(input int v, input string name);
        num = 13'(v);
        tick();
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL %s busy start: got %b required 1", name, busy);
        end
    endtask

    task automatic test_reset();
        int highs = 0;
        rst = 1'b0;
        num = 13'd0;
        repeat (3) tick();
        tests++;
        if (Anode !== 4'b1111 || LED_out !== 7'b1111111 || busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: got %b/%b/%b required 1111/1111111/0", Anode, LED_out, busy);
        end
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (busy) highs++;
            tests++;
            if (Anode !== anode_of(((k - 1) / 4) % 4)) begin
                failed++;
                $display("FAIL anode_seq k=%0d: got %b required %b", k, Anode,
                         anode_of(((k - 1) / 4) % 4));
            end
            if (k <= 15) begin
                tests++;
                if (LED_out !== 7'b1111111) begin
                    failed++;
                    $display("FAIL blank_after_reset k=%0d: got %b required 1111111", k, LED_out);
                end
            end
        end
        tests++;
        if (highs != 14) begin
            failed++;
            $display("FAIL forced_conv busy cycles: got %0d required 14", highs);
        end
        check_scan(0, "zero", 16);
    endtask

    task automatic test_max();
        start_conv(8191, "max");
        wait_done("max");
        check_scan(8191, "max", 16);
    endtask

    task automatic test_back_to_back();
        int lows = 1;
        start_conv(1234, "b2b_first");
        repeat (4) tick();
        num = 13'd5678;
        wait_done("b2b_first");
        while (!busy && lows < 6) begin
            tick();
            if (!busy) lows++;
        end
        tests++;
        if (lows != 1) begin
            failed++;
            $display("FAIL b2b idle gap: got %0d required 1", lows);
        end
        check_scan(1234, "b2b_first", 10);
        wait_done("b2b_second");
        check_scan(5678, "b2b_second", 16);
    endtask

    task automatic test_reset_mid();
        start_conv(4321, "rst_mid");
        repeat (6) tick();
        rst = 1'b0;
        tick();
        tests++;
        if (Anode !== 4'b1111 || LED_out !== 7'b1111111 || busy !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid outputs: got %b/%b/%b required 1111/1111111/0", Anode, LED_out, busy);
        end
        rst = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            tests++;
            if (LED_out !== 7'b1111111) begin
                failed++;
                $display("FAIL rst_mid blank k=%0d: got %b required 1111111", k, LED_out);
            end
        end
        check_scan(4321, "rst_mid", 16);
    endtask

    task automatic test_random();
        int vals[$];
        int cur = 4321;
        int v;
        vals = '{9, 10, 99, 100, 999, 1000, 42};
        for (int i = 0; i < 10; i++) vals.push_back(int'($urandom_range(0, 8191)));
        foreach (vals[i]) begin
            v = vals[i];
            if (v == cur) v = (v + 1) % 8192;
            start_conv(v, "rand");
            wait_done("rand");
            check_scan(v, "rand", 16);
            cur = v;
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
